// File: rtl/tlc_phase_scheduler.sv
// Two-lane traffic light phase scheduler with emergency preempt.
// Drives lane lights and per-lane queue counter up/down commands.
module tlc_phase_scheduler #(
   parameter int MIN_GREEN = 4,
   parameter int MAX_GREEN = 12,
   parameter int YEL_T     = 2,
   parameter int AR_T      = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       car_ns,
   input  logic       car_ew,
   input  logic [3:0] cnt_ns,
   input  logic [3:0] cnt_ew,
   input  logic       emg,
   input  logic       emg_dir,
   output logic [1:0] w_ns,
   output logic [1:0] w_ew,
   output logic [1:0] lt_ns,
   output logic [1:0] lt_ew,
   output logic       busy_emg
);

   typedef enum logic [2:0] {
      AR_NS,
      NS_G,
      NS_Y,
      AR_EW,
      EW_G,
      EW_Y
   } state_t;

   localparam logic [4:0] MIN_P = 5'(MIN_GREEN);
   localparam logic [4:0] MAX_P = 5'(MAX_GREEN);
   localparam logic [4:0] YEL_P = 5'(YEL_T);
   localparam logic [4:0] AR_P  = 5'(AR_T);

   state_t     state_q;
   state_t     state_d;
   logic [3:0] timer_q;
   logic [4:0] tnext;
   logic       ns_green;
   logic       ew_green;
   logic       ns_has;
   logic       ew_has;

   assign tnext    = {1'b0, timer_q} + 5'd1;
   assign ns_green = (state_q == NS_G);
   assign ew_green = (state_q == EW_G);
   assign ns_has   = (cnt_ns != 4'd0);
   assign ew_has   = (cnt_ew != 4'd0);

   // Next phase; only a tick can move the phase.
   always_comb begin
      state_d = state_q;
      if (tick) begin
         case (state_q)
            AR_NS: if (tnext >= AR_P) state_d = NS_G;
            NS_G: begin
               if (emg) begin
                  if (emg_dir) state_d = NS_Y;
               end else if (ew_has && tnext >= MIN_P &&
                            (!ns_has || tnext >= MAX_P)) begin
                  state_d = NS_Y;
               end
            end
            NS_Y:  if (tnext >= YEL_P) state_d = AR_EW;
            AR_EW: if (tnext >= AR_P) state_d = EW_G;
            EW_G: begin
               if (emg) begin
                  if (!emg_dir) state_d = EW_Y;
               end else if (ns_has && tnext >= MIN_P &&
                            (!ew_has || tnext >= MAX_P)) begin
                  state_d = EW_Y;
               end
            end
            EW_Y:    if (tnext >= YEL_P) state_d = AR_NS;
            default: state_d = AR_NS;
         endcase
      end
   end

   // Phase register and saturating dwell timer, cleared on phase change.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= AR_NS;
         timer_q <= 4'd0;
      end else begin
         state_q <= state_d;
         if (state_d != state_q) begin
            timer_q <= 4'd0;
         end else if (tick && timer_q != 4'hF) begin
            timer_q <= timer_q + 4'd1;
         end
      end
   end

   // Lights decode purely from the registered phase.
   always_comb begin
      lt_ns = 2'b00;
      lt_ew = 2'b00;
      case (state_q)
         NS_G:    lt_ns = 2'b10;
         NS_Y:    lt_ns = 2'b01;
         EW_G:    lt_ew = 2'b10;
         EW_Y:    lt_ew = 2'b01;
         default: begin
            lt_ns = 2'b00;
            lt_ew = 2'b00;
         end
      endcase
   end

   // Arrival counts up; departures only leave a green, non-empty lane.
   assign w_ns = rst_n ? {tick & ns_green & ns_has, car_ns} : 2'b00;
   assign w_ew = rst_n ? {tick & ew_green & ew_has, car_ew} : 2'b00;

   assign busy_emg = rst_n & emg & (emg_dir ? ew_green : ns_green);

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Bench for tlc_phase_scheduler: directed scenarios plus randomized
// traffic compared against a lane/colour/elapsed-ticks model.
module tb_tlc_phase_scheduler;

   localparam int MIN_GREEN = 4;
   localparam int MAX_GREEN = 12;
   localparam int YEL_T     = 2;
   localparam int AR_T      = 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b0;
   logic       car_ns = 1'b0;
   logic       car_ew = 1'b0;
   logic [3:0] cnt_ns = 4'd0;
   logic [3:0] cnt_ew = 4'd0;
   logic       emg = 1'b0;
   logic       emg_dir = 1'b0;
   logic [1:0] w_ns, w_ew, lt_ns, lt_ew;
   logic       busy_emg;

   int n_tests = 0;
   int n_fail  = 0;

   // model: which lane owns the cycle, its colour, ticks spent so far
   int m_lane;   // 0 = NS, 1 = EW
   int m_col;    // 0 = red (all red), 1 = green, 2 = yellow
   int m_el;

   tlc_phase_scheduler #(
      .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN),
      .YEL_T(YEL_T), .AR_T(AR_T)
   ) dut (
      .clk(clk), .rst_n(rst_n), .tick(tick),
      .car_ns(car_ns), .car_ew(car_ew),
      .cnt_ns(cnt_ns), .cnt_ew(cnt_ew),
      .emg(emg), .emg_dir(emg_dir),
      .w_ns(w_ns), .w_ew(w_ew),
      .lt_ns(lt_ns), .lt_ew(lt_ew),
      .busy_emg(busy_emg)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] exp_lt(input int lane);
      if (m_lane != lane) return 2'b00;
      if (m_col == 1) return 2'b10;
      if (m_col == 2) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic is_green(input int lane);
      return (m_lane == lane) && (m_col == 1);
   endfunction

   function automatic logic [1:0] exp_w(input int lane);
      logic car;
      logic [3:0] c;
      car = (lane == 0) ? car_ns : car_ew;
      c   = (lane == 0) ? cnt_ns : cnt_ew;
      if (!rst_n) return 2'b00;
      return {tick && is_green(lane) && c != 0, car};
   endfunction

   function automatic logic exp_busy();
      return rst_n && emg && is_green(emg_dir ? 1 : 0);
   endfunction

   task automatic model_update();
      int  mine, other;
      bit  go;
      if (!rst_n) begin
         m_lane = 0; m_col = 0; m_el = 0;
         return;
      end
      if (!tick) return;
      go = 0;
      mine  = (m_lane == 0) ? int'(cnt_ns) : int'(cnt_ew);
      other = (m_lane == 0) ? int'(cnt_ew) : int'(cnt_ns);
      case (m_col)
         0: go = (m_el + 1 >= AR_T);
         1: begin
            if (emg) go = (int'(emg_dir) != m_lane);
            else go = other != 0 && m_el + 1 >= MIN_GREEN &&
                      (mine == 0 || m_el + 1 >= MAX_GREEN);
         end
         default: go = (m_el + 1 >= YEL_T);
      endcase
      if (go) begin
         m_el = 0;
         if (m_col == 2) begin
            m_col  = 0;
            m_lane = 1 - m_lane;
         end else begin
            m_col = m_col + 1;
         end
      end else begin
         m_el = m_el + 1;
      end
   endtask

   task automatic clock();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic quiet();
      tick = 0; car_ns = 0; car_ew = 0; emg = 0; emg_dir = 0;
   endtask

   task automatic do_reset();
      quiet();
      rst_n = 0;
      clock();
      rst_n = 1;
   endtask

   // ticks until lane light becomes want; returns -1 on timeout
   task automatic ticks_until(input int lane, input logic [1:0] want,
                              output int n);
      n = -1;
      tick = 1;
      for (int i = 1; i <= 40; i++) begin
         clock();
         if (((lane == 0) ? lt_ns : lt_ew) == want) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      quiet();
      rst_n = 0; tick = 1; car_ns = 1; car_ew = 1;
      cnt_ns = 4'd5; cnt_ew = 4'd5; emg = 1;
      #1;
      n_tests++;
      if (w_ns !== 2'b00 || w_ew !== 2'b00 || busy_emg !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outs: w_ns=%b w_ew=%b busy=%b want 00 00 0",
                  w_ns, w_ew, busy_emg);
      end
      clock();
      n_tests++;
      if (lt_ns !== 2'b00 || lt_ew !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_lights: %b/%b want 00/00", lt_ns, lt_ew);
      end
      rst_n = 1;
      quiet();
   endtask

   task automatic test_ns_hold();
      int bad;
      do_reset();
      tick = 1;
      clock();
      n_tests++;
      if (lt_ns !== 2'b10 || lt_ew !== 2'b00) begin
         n_fail++;
         $display("FAIL first_green: %b/%b want 10/00", lt_ns, lt_ew);
      end
      cnt_ns = 4'd3; cnt_ew = 4'd0;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (w_ns !== 2'b10) bad++;
         clock();
         if (lt_ns !== 2'b10) bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL ns_hold: %0d bad cycles want 0", bad);
      end
   endtask

   task automatic test_max_green();
      int n;
      do_reset();
      tick = 1;
      clock();
      cnt_ns = 4'd5; cnt_ew = 4'd2;
      ticks_until(0, 2'b01, n);
      n_tests++;
      if (n != MAX_GREEN) begin
         n_fail++;
         $display("FAIL max_green: yellow after %0d want %0d", n, MAX_GREEN);
      end
      ticks_until(1, 2'b10, n);
      n_tests++;
      if (n != YEL_T + AR_T) begin
         n_fail++;
         $display("FAIL to_ew_green: %0d ticks want %0d", n, YEL_T + AR_T);
      end
   endtask

   task automatic test_min_green();
      int n;
      do_reset();
      tick = 1;
      clock();
      cnt_ns = 4'd0; cnt_ew = 4'd1;
      ticks_until(0, 2'b01, n);
      n_tests++;
      if (n != MIN_GREEN) begin
         n_fail++;
         $display("FAIL min_green: yellow after %0d want %0d", n, MIN_GREEN);
      end
   endtask

   task automatic goto_ew_green();
      int n;
      do_reset();
      tick = 1;
      clock();
      cnt_ns = 4'd0; cnt_ew = 4'd1;
      ticks_until(1, 2'b10, n);
      n_tests++;
      if (n != MIN_GREEN + YEL_T + AR_T) begin
         n_fail++;
         $display("FAIL reach_ew: %0d ticks want %0d", n,
                  MIN_GREEN + YEL_T + AR_T);
      end
   endtask

   task automatic test_emg();
      int bad;
      goto_ew_green();
      cnt_ns = 4'd0; cnt_ew = 4'd1; tick = 1;
      clock();
      emg = 1; emg_dir = 0;
      clock();
      n_tests++;
      if (lt_ew !== 2'b01 || lt_ns !== 2'b00 || busy_emg !== 1'b0) begin
         n_fail++;
         $display("FAIL emg_yellow: %b/%b busy=%b want 00/01 0",
                  lt_ns, lt_ew, busy_emg);
      end
      for (int i = 0; i < YEL_T; i++) clock();
      n_tests++;
      if (lt_ns !== 2'b00 || lt_ew !== 2'b00) begin
         n_fail++;
         $display("FAIL emg_allred: %b/%b want 00/00", lt_ns, lt_ew);
      end
      clock();
      n_tests++;
      if (lt_ns !== 2'b10 || busy_emg !== 1'b1) begin
         n_fail++;
         $display("FAIL emg_ns_green: lt_ns=%b busy=%b want 10 1",
                  lt_ns, busy_emg);
      end
      cnt_ew = 4'd5; cnt_ns = 4'd0;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         clock();
         if (lt_ns !== 2'b10 || busy_emg !== 1'b1) bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL emg_hold: %0d bad cycles want 0", bad);
      end
      emg = 0;
      #1;
      n_tests++;
      if (busy_emg !== 1'b0) begin
         n_fail++;
         $display("FAIL emg_release_busy: %b want 0", busy_emg);
      end
      clock();
      n_tests++;
      if (lt_ns !== 2'b01) begin
         n_fail++;
         $display("FAIL emg_resume: lt_ns=%b want 01", lt_ns);
      end
   endtask

   task automatic test_arrival_departure();
      goto_ew_green();
      tick = 1; cnt_ew = 4'd4; cnt_ns = 4'd0;
      car_ew = 1; car_ns = 1;
      #1;
      n_tests++;
      if (w_ew !== 2'b11 || w_ns !== 2'b01) begin
         n_fail++;
         $display("FAIL arr_dep: w_ew=%b w_ns=%b want 11 01", w_ew, w_ns);
      end
      tick = 0;
      #1;
      n_tests++;
      if (w_ew !== 2'b01) begin
         n_fail++;
         $display("FAIL no_tick_dep: w_ew=%b want 01", w_ew);
      end
      quiet();
   endtask

   task automatic test_reset_mid_yellow();
      int n;
      do_reset();
      tick = 1;
      clock();
      cnt_ns = 4'd0; cnt_ew = 4'd1;
      ticks_until(0, 2'b01, n);
      rst_n = 0; tick = 1; car_ns = 1; car_ew = 1; emg = 1;
      #1;
      n_tests++;
      if (w_ns !== 2'b00 || w_ew !== 2'b00 || busy_emg !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_yel_outs: %b %b %b want 00 00 0",
                  w_ns, w_ew, busy_emg);
      end
      clock();
      quiet();
      rst_n = 1;
      n_tests++;
      if (lt_ns !== 2'b00 || lt_ew !== 2'b00) begin
         n_fail++;
         $display("FAIL rst_yel_lights: %b/%b want 00/00", lt_ns, lt_ew);
      end
      tick = 1;
      clock();
      n_tests++;
      if (lt_ns !== 2'b10) begin
         n_fail++;
         $display("FAIL rst_yel_restart: lt_ns=%b want 10", lt_ns);
      end
      quiet();
   endtask

   task automatic test_random();
      int bad_w, bad_lt, bad_excl;
      do_reset();
      bad_w = 0; bad_lt = 0; bad_excl = 0;
      for (int i = 0; i < 3000; i++) begin
         rst_n  = ($urandom_range(0, 99) != 0);
         tick   = ($urandom_range(0, 2) != 0);
         car_ns = $urandom_range(0, 1) != 0;
         car_ew = $urandom_range(0, 1) != 0;
         cnt_ns = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         cnt_ew = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         if ($urandom_range(0, 39) == 0) emg = ~emg;
         if ($urandom_range(0, 59) == 0) emg_dir = ~emg_dir;
         #1;
         if (w_ns !== exp_w(0) || w_ew !== exp_w(1) ||
             busy_emg !== exp_busy()) begin
            bad_w++;
            if (bad_w <= 3)
               $display("FAIL rand_comb cyc %0d: w %b %b busy %b want %b %b %b",
                        i, w_ns, w_ew, busy_emg, exp_w(0), exp_w(1), exp_busy());
         end
         clock();
         if (lt_ns !== exp_lt(0) || lt_ew !== exp_lt(1)) begin
            bad_lt++;
            if (bad_lt <= 3)
               $display("FAIL rand_lights cyc %0d: %b/%b want %b/%b",
                        i, lt_ns, lt_ew, exp_lt(0), exp_lt(1));
         end
         if (lt_ns != 2'b00 && lt_ew != 2'b00) bad_excl++;
      end
      n_tests++;
      if (bad_w != 0) begin
         n_fail++;
         $display("FAIL rand_comb_total: %0d bad want 0", bad_w);
      end
      n_tests++;
      if (bad_lt != 0) begin
         n_fail++;
         $display("FAIL rand_lights_total: %0d bad want 0", bad_lt);
      end
      n_tests++;
      if (bad_excl != 0) begin
         n_fail++;
         $display("FAIL rand_exclusive: %0d both-lit cycles want 0", bad_excl);
      end
      quiet();
      rst_n = 1;
   endtask

   initial begin
      m_lane = 0; m_col = 0; m_el = 0;
      #2;
      test_reset();
      test_ns_hold();
      test_max_green();
      test_min_green();
      test_emg();
      test_arrival_departure();
      test_reset_mid_yellow();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
